// File: rtl/bram_pio_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bram_pio_reader                                                |
// | Brief   : Reads a programmed range of the ADC capture RAM and emits it   |
// |           word by word on a PIO write port with ready backpressure.      |
// |           Optional running checksum: BRAM_PIO_READER_CHECKSUM_EN.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bram_pio_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [ADDR_W:0]       i_word_count,
  output logic [ADDR_W-1:0]     o_rd_addr,
  input  logic [DATA_W-1:0]     i_rd_q,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic [DATA_W/8-1:0]   o_wr_byteen,
  output logic                  o_wr_en,
  input  logic                  i_wr_ready,
  output logic                  o_busy,
  output logic                  o_done
`ifdef BRAM_PIO_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     o_checksum
`endif
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_FIN   = 3'd4;

  localparam logic [2:0]      c_LAT_LOAD = 3'(RD_LATENCY - 1);
  localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_CNT_ZERO = '0;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remain;
  logic [2:0]        r_lat;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;
  logic              w_first_issue;

  assign w_accept      = (r_state == c_WRITE) && i_wr_ready;
  assign w_first_issue = (r_state == c_IDLE) && i_start && (i_word_count != c_CNT_ZERO);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The first read is presented straight from IDLE so a
  // nonzero start skips ISSUE; ISSUE with nothing left routes to FIN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (i_start) begin
          w_next_state = (i_word_count == c_CNT_ZERO) ? c_ISSUE : c_WAIT;
        end
      end
      c_ISSUE: begin
        w_next_state = (r_remain == c_CNT_ZERO) ? c_FIN : c_WAIT;
      end
      c_WAIT: begin
        if (r_lat == 3'd0) begin
          w_next_state = c_WRITE;
        end
      end
      c_WRITE: begin
        if (i_wr_ready) begin
          w_next_state = (r_remain == c_CNT_ONE) ? c_FIN : c_ISSUE;
        end
      end
      c_FIN: begin
        w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Datapath: pointers, remaining count, latency counter and data capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_remain <= '0;
      r_lat    <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_start) begin
            r_rd_ptr <= i_base_addr;
            r_wr_ptr <= '0;
            r_remain <= i_word_count;
            r_lat    <= c_LAT_LOAD;
          end
        end
        c_ISSUE: begin
          r_lat <= c_LAT_LOAD;
        end
        c_WAIT: begin
          if (r_lat == 3'd0) begin
            r_data <= i_rd_q;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        c_WRITE: begin
          if (w_accept) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_remain <= r_remain - c_CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BRAM_PIO_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else if ((r_state == c_IDLE) && i_start) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

  // Output decode
  always_comb begin
    o_rd_addr   = '0;
    o_wr_addr   = '0;
    o_wr_data   = '0;
    o_wr_byteen = '0;
    o_wr_en     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_first_issue && !i_reset) begin
          o_rd_addr = i_base_addr;
        end
      end
      c_ISSUE, c_WAIT: begin
        o_rd_addr = r_rd_ptr;
        o_busy    = 1'b1;
      end
      c_WRITE: begin
        o_rd_addr   = r_rd_ptr;
        o_busy      = 1'b1;
        o_wr_en     = 1'b1;
        o_wr_addr   = r_wr_ptr;
        o_wr_data   = r_data;
        o_wr_byteen = '1;
      end
      c_FIN: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_pio_reader.sv
`default_nettype none
// Testbench for bram_pio_reader: RAM with read latency, timeline-based reference
// model of the write bus, per-cycle compare plus literal spot checks.
module tb_bram_pio_reader;
  localparam int AW    = 14;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int MAXC  = 256;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            i_reset, i_start, i_wr_ready;
  logic [AW-1:0]   i_base_addr;
  logic [AW:0]     i_word_count;
  logic [AW-1:0]   o_rd_addr, o_wr_addr;
  logic [DW-1:0]   i_rd_q, o_wr_data;
  logic [DW/8-1:0] o_wr_byteen;
  logic            o_wr_en, o_busy, o_done;
`ifdef BRAM_PIO_READER_CHECKSUM_EN
  logic [DW-1:0]   o_checksum;
`endif

  always #5 clk = ~clk;

  bram_pio_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_word_count(i_word_count),
    .o_rd_addr(o_rd_addr), .i_rd_q(i_rd_q),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_byteen(o_wr_byteen),
    .o_wr_en(o_wr_en), .i_wr_ready(i_wr_ready),
    .o_busy(o_busy), .o_done(o_done)
`ifdef BRAM_PIO_READER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  // RAM: data for an address appears LAT cycles after it is presented
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] qpipe [LAT];
  assign i_rd_q = qpipe[LAT-1];
  always @(posedge clk) begin
    qpipe[0] <= ram[o_rd_addr];
    for (int i = 1; i < LAT; i++) qpipe[i] <= qpipe[i-1];
  end

  // Expected per-cycle trace, cycle 0 = cycle in which i_start is presented
  bit            rdy    [MAXC];
  bit            e_en   [MAXC];
  int            e_addr [MAXC];
  logic [DW-1:0] e_data [MAXC];
  bit            e_busy [MAXC];
  bit            e_done [MAXC];
  logic [DW-1:0] obs_data [MAXC];
`ifdef BRAM_PIO_READER_CHECKSUM_EN
  bit            e_ck_v [MAXC];
  logic [DW-1:0] e_ck   [MAXC];
  logic [DW-1:0] obs_ck;
`endif
  int  exp_done;
  int  first_done;
  int  cur_c;
  bit  chk;
  int  tests, fails;

  task automatic clear_trace();
    for (int c = 0; c < MAXC; c++) begin
      e_en[c] = 0; e_addr[c] = 0; e_data[c] = '0; e_busy[c] = 0; e_done[c] = 0;
`ifdef BRAM_PIO_READER_CHECKSUM_EN
      e_ck_v[c] = 0; e_ck[c] = '0;
`endif
    end
  endtask

  // Word k is offered from t until the first ready cycle a; the next word
  // is offered LAT+2 cycles after that acceptance. First word at LAT+1.
  task automatic build(input int base, input int count, input int rst_at);
    int t, a, last_a;
    logic [DW-1:0] sum;
    clear_trace();
    sum = '0;
    if (count == 0) begin
      e_busy[1] = 1;
      exp_done  = 2;
    end else begin
      t = LAT + 1;
      last_a = t;
      for (int k = 0; k < count; k++) begin
        a = t;
        while (!rdy[a] && a < MAXC - 8) a++;
        for (int c = t; c <= a; c++) begin
          e_en[c]   = 1;
          e_addr[c] = k % DEPTH;
          e_data[c] = ram[(base + k) % DEPTH];
        end
        sum    = sum + ram[(base + k) % DEPTH];
        last_a = a;
        t      = a + LAT + 2;
      end
      for (int c = 1; c <= last_a; c++) e_busy[c] = 1;
      exp_done = last_a + 1;
    end
    e_done[exp_done] = 1;
`ifdef BRAM_PIO_READER_CHECKSUM_EN
    for (int c = exp_done; c < MAXC; c++) begin
      e_ck_v[c] = 1; e_ck[c] = sum;
    end
`endif
    if (rst_at >= 0) begin
      for (int c = rst_at + 1; c < MAXC; c++) begin
        e_en[c] = 0; e_addr[c] = 0; e_data[c] = '0; e_busy[c] = 0; e_done[c] = 0;
`ifdef BRAM_PIO_READER_CHECKSUM_EN
        e_ck_v[c] = 0;
`endif
      end
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (o_wr_en !== e_en[cur_c] || o_wr_addr !== AW'(e_addr[cur_c]) ||
          o_wr_data !== e_data[cur_c] || o_wr_byteen !== (e_en[cur_c] ? 8'hFF : 8'h00)) begin
        fails++;
        $display("FAIL wr_bus cyc=%0d got en=%b addr=%0d data=%h be=%h, want en=%b addr=%0d data=%h",
                 cur_c, o_wr_en, o_wr_addr, o_wr_data, o_wr_byteen, e_en[cur_c], e_addr[cur_c], e_data[cur_c]);
      end
      tests++;
      if (o_busy !== e_busy[cur_c]) begin
        fails++;
        $display("FAIL busy cyc=%0d got %b want %b", cur_c, o_busy, e_busy[cur_c]);
      end
      tests++;
      if (o_done !== e_done[cur_c]) begin
        fails++;
        $display("FAIL done cyc=%0d got %b want %b", cur_c, o_done, e_done[cur_c]);
      end
`ifdef BRAM_PIO_READER_CHECKSUM_EN
      if (e_ck_v[cur_c]) begin
        tests++;
        if (o_checksum !== e_ck[cur_c]) begin
          fails++;
          $display("FAIL checksum cyc=%0d got %h want %h", cur_c, o_checksum, e_ck[cur_c]);
        end
      end
      if (o_done === 1'b1 && first_done < 0) obs_ck = o_checksum;
`endif
      obs_data[cur_c] = o_wr_data;
      if (o_done === 1'b1 && first_done < 0) first_done = cur_c;
    end
  end

  task automatic check_lit(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic set_rdy_all(input bit v);
    for (int c = 0; c < MAXC; c++) rdy[c] = v;
  endtask

  // Runs one transfer; entered just after a rising edge
  task automatic run(input int base, input int count, input int rst_at);
    int len;
    build(base, count, rst_at);
    len = (rst_at >= 0) ? rst_at + 4 : exp_done + 3;
    first_done = -1;
    for (int c = 0; c < len; c++) begin
      cur_c = c;
      chk   = 1;
      if (c == 0) begin
        i_start      = 1'b1;
        i_base_addr  = AW'(base);
        i_word_count = (AW+1)'(count);
      end else begin
        i_start      = (rst_at < 0) && (c <= exp_done) && ($urandom_range(0, 3) == 0);
        i_base_addr  = AW'($urandom_range(0, DEPTH - 1));
        i_word_count = (AW+1)'($urandom_range(0, 20));
      end
      i_wr_ready = rdy[c];
      i_reset    = (c == rst_at);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    chk = 0;
    i_start = 1'b0;
    i_reset = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; chk = 0; cur_c = 0; first_done = -1; exp_done = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = {$urandom, $urandom};
    for (int i = 0; i < LAT; i++) qpipe[i] = '0;
    set_rdy_all(1);
    clear_trace();

    // Reset held with start asserted: everything stays quiet
    i_reset = 1'b1; i_start = 1'b1; i_base_addr = AW'(5); i_word_count = (AW+1)'(4); i_wr_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      cur_c = c; chk = 1;
      @(negedge clk); @(posedge clk); #1;
    end
    i_reset = 1'b0; i_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cur_c = c; chk = 1;
      @(negedge clk); @(posedge clk); #1;
    end
    chk = 0;
    check_lit("reset_no_done", DW'(first_done + 1), 64'd0);

    // Basic 4-word transfer
    ram[5] = 64'h1111_1111_1111_1111; ram[6] = 64'h2222_2222_2222_2222;
    ram[7] = 64'h3333_3333_3333_3333; ram[8] = 64'h4444_4444_4444_4444;
    set_rdy_all(1);
    run(5, 4, -1);
    check_lit("basic_done_cycle", DW'(first_done), 64'd16);
    check_lit("basic_word0", obs_data[3], 64'h1111_1111_1111_1111);
    check_lit("basic_word3", obs_data[15], 64'h4444_4444_4444_4444);

    // Backpressure on the second word
    set_rdy_all(1);
    for (int c = 7; c <= 11; c++) rdy[c] = 0;
    run(5, 4, -1);
    check_lit("bp_done_cycle", DW'(first_done), 64'd21);
    check_lit("bp_word1_held", obs_data[12], 64'h2222_2222_2222_2222);

    // Address wrap
    ram[DEPTH-1] = 64'hAAAA_0000_0000_3FFF; ram[0] = 64'hAAAA_0000_0000_0000; ram[1] = 64'hAAAA_0000_0000_0001;
    set_rdy_all(1);
    run(DEPTH - 1, 3, -1);
    check_lit("wrap_word1", obs_data[7], 64'hAAAA_0000_0000_0000);
    check_lit("wrap_word2", obs_data[11], 64'hAAAA_0000_0000_0001);

    // Zero count
    run(100, 0, -1);
    check_lit("zero_done_cycle", DW'(first_done), 64'd2);

    // Reset during the second word's read wait, then a fresh 1-word transfer
    run(5, 4, 5);
    check_lit("abort_no_done", DW'(first_done + 1), 64'd0);
    ram[0] = 64'h0123_4567_89AB_CDEF;
    run(0, 1, -1);
    check_lit("after_abort_done", DW'(first_done), 64'd4);
    check_lit("after_abort_word", obs_data[3], 64'h0123_4567_89AB_CDEF);

`ifdef BRAM_PIO_READER_CHECKSUM_EN
    ram[200] = 64'd1; ram[201] = 64'd2; ram[202] = 64'd3; ram[203] = 64'hFFFF_FFFF_FFFF_FFFF;
    set_rdy_all(1);
    run(200, 4, -1);
    check_lit("checksum_literal", obs_ck, 64'h5);
`endif

    // Randomized transfers with random backpressure
    for (int n = 0; n < 12; n++) begin
      int b, cnt;
      for (int c = 0; c < MAXC; c++) rdy[c] = ($urandom_range(0, 2) != 0) || (c % 6 == 5);
      b   = $urandom_range(0, DEPTH - 1);
      cnt = (n % 5 == 4) ? 0 : $urandom_range(1, 8);
      run(b, cnt, -1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
